// File: rtl/count_phase_tracker_if.sv
// ---------------------------------------------------------------------------
// count_phase_tracker_if
//   Groups the sequence-tracker data signals so the tracker and whoever feeds
//   it can be wired with a single connection. Clock and reset stay outside.
//
//   Parameters: MOD (sequence modulus), Q_W (Q_IN width), CNT_W (CYCLES width)
//
//   Signals:
//     Q_IN    count value from the upstream mod-MOD counter
//     CLR     synchronous clear back to the unlocked, error-free state
//     PHASE   one-hot of the last accepted Q_IN, zero when not locked
//     WRAP    one-cycle pulse per accepted MOD-1 -> 0 step
//     CYCLES  completed-cycle count, wraps modulo 2**CNT_W
//     LOCKED  high while the tracker follows the sequence
//     ERR     sticky sequence-fault flag
//
//   Modports:
//     master  side that supplies Q_IN/CLR and observes the results
//     slave   the tracker itself
// ---------------------------------------------------------------------------
interface count_phase_tracker_if #(
    parameter int MOD   = 5,
    parameter int Q_W   = 3,
    parameter int CNT_W = 8
);
    logic [Q_W-1:0]   Q_IN;
    logic             CLR;
    logic [MOD-1:0]   PHASE;
    logic             WRAP;
    logic [CNT_W-1:0] CYCLES;
    logic             LOCKED;
    logic             ERR;

    modport master (
        output Q_IN,
        output CLR,
        input  PHASE,
        input  WRAP,
        input  CYCLES,
        input  LOCKED,
        input  ERR
    );

    modport slave (
        input  Q_IN,
        input  CLR,
        output PHASE,
        output WRAP,
        output CYCLES,
        output LOCKED,
        output ERR
    );
endinterface

// File: rtl/count_phase_tracker.sv
// ---------------------------------------------------------------------------
// count_phase_tracker
//   Watches the Q output of an upstream mod-MOD sequence counter. Once it sees
//   a 0 it locks on, presents the current value as a registered one-hot PHASE,
//   pulses WRAP on each MOD-1 -> 0 rollover and counts completed cycles in
//   CYCLES. Any step off the sequence 0,1,..,MOD-1,0,.. drops lock and sets a
//   sticky ERR that only CLR or RESET removes.
//
//   Ports:
//     CLK    rising-edge clock, shared with the upstream counter
//     RESET  synchronous, active-high reset
//     bus    count_phase_tracker_if.slave (Q_IN, CLR in; PHASE, WRAP,
//            CYCLES, LOCKED, ERR out), all outputs registered
//
//   Build option:
//     TRACKER_HOLD_EN  when defined, Q_IN repeating its previous value while
//                      locked is a legal hold (clock-enabled upstream);
//                      when undefined, a repeat is a sequence fault.
// ---------------------------------------------------------------------------
module count_phase_tracker #(
    parameter int MOD   = 5,
    parameter int Q_W   = 3,
    parameter int CNT_W = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    count_phase_tracker_if.slave  bus
);

    localparam logic [1:0] SYNC  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    localparam logic [Q_W-1:0] LAST      = Q_W'(MOD - 1);
    localparam logic [MOD-1:0] PHASE_ONE = MOD'(1);

    logic [1:0]       state;
    logic [Q_W-1:0]   prev_q;
    logic [Q_W-1:0]   exp_q;
    logic [MOD-1:0]   phase_r;
    logic             wrap_r;
    logic [CNT_W-1:0] cycles_r;
    logic             locked_r;
    logic             err_r;

    // Next legal value after the last accepted one.
    always_comb begin
        exp_q = (prev_q == LAST) ? '0 : prev_q + Q_W'(1);
    end

    // RESET and CLR share one branch; WRAP defaults low so it can only ever
    // be a single-cycle pulse on an accepted rollover.
    always_ff @(posedge CLK) begin
        if (RESET || bus.CLR) begin
            state    <= SYNC;
            prev_q   <= '0;
            phase_r  <= '0;
            wrap_r   <= 1'b0;
            cycles_r <= '0;
            locked_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            case (state)
                SYNC: begin
                    if (bus.Q_IN == '0) begin
                        state    <= TRACK;
                        prev_q   <= '0;
                        phase_r  <= PHASE_ONE;
                        locked_r <= 1'b1;
                    end
                end
                TRACK: begin
                    if (bus.Q_IN == exp_q) begin
                        prev_q  <= bus.Q_IN;
                        phase_r <= PHASE_ONE << bus.Q_IN;
                        if (prev_q == LAST) begin
                            wrap_r   <= 1'b1;
                            cycles_r <= cycles_r + CNT_W'(1);
                        end
                    end else if (bus.Q_IN == prev_q) begin
`ifdef TRACKER_HOLD_EN
                        // Upstream is stalled: keep PHASE and CYCLES as they are.
                        state <= TRACK;
`else
                        state    <= FAULT;
                        err_r    <= 1'b1;
                        locked_r <= 1'b0;
                        phase_r  <= '0;
`endif
                    end else begin
                        state    <= FAULT;
                        err_r    <= 1'b1;
                        locked_r <= 1'b0;
                        phase_r  <= '0;
                    end
                end
                FAULT: begin
                    err_r    <= 1'b1;
                    locked_r <= 1'b0;
                    phase_r  <= '0;
                end
                default: begin
                    state    <= SYNC;
                    locked_r <= 1'b0;
                    phase_r  <= '0;
                end
            endcase
        end
    end

    assign bus.PHASE  = phase_r;
    assign bus.WRAP   = wrap_r;
    assign bus.CYCLES = cycles_r;
    assign bus.LOCKED = locked_r;
    assign bus.ERR    = err_r;

endmodule

// File: tb/tb_count_phase_tracker.sv
// ---------------------------------------------------------------------------
// tb_count_phase_tracker
//   Directed bench for count_phase_tracker (MOD=5, Q_W=3, CNT_W=8). Each step
//   drives Q_IN/CLR/RESET, waits one rising edge, then samples the registered
//   outputs 1 ns later against hand-computed values.
// ---------------------------------------------------------------------------
module tb_count_phase_tracker;

    logic CLK;
    logic RESET;
    int   testsRun;
    int   testsFailed;

    count_phase_tracker_if #(.MOD(5), .Q_W(3), .CNT_W(8)) bus ();

    count_phase_tracker #(.MOD(5), .Q_W(3), .CNT_W(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one set of inputs and let one rising edge consume them.
    task automatic applyStimulus(input logic [2:0] q, input logic clr, input logic rst);
        bus.Q_IN = q;
        bus.CLR  = clr;
        RESET    = rst;
        @(posedge CLK);
        #1;
    endtask

    // Compare every output against its expected value.
    task automatic checkOutput(input string tag, input logic [4:0] expPhase,
                               input logic expWrap, input logic [7:0] expCycles,
                               input logic expLocked, input logic expErr);
        testsRun++;
        assert (bus.PHASE === expPhase) else begin
            testsFailed++;
            $error("[TB] FAIL %s PHASE observed %h expected %h", tag, bus.PHASE, expPhase);
        end
        testsRun++;
        assert (bus.WRAP === expWrap) else begin
            testsFailed++;
            $error("[TB] FAIL %s WRAP observed %b expected %b", tag, bus.WRAP, expWrap);
        end
        testsRun++;
        assert (bus.CYCLES === expCycles) else begin
            testsFailed++;
            $error("[TB] FAIL %s CYCLES observed %0d expected %0d", tag, bus.CYCLES, expCycles);
        end
        testsRun++;
        assert (bus.LOCKED === expLocked) else begin
            testsFailed++;
            $error("[TB] FAIL %s LOCKED observed %b expected %b", tag, bus.LOCKED, expLocked);
        end
        testsRun++;
        assert (bus.ERR === expErr) else begin
            testsFailed++;
            $error("[TB] FAIL %s ERR observed %b expected %b", tag, bus.ERR, expErr);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        bus.Q_IN    = 3'd0;
        bus.CLR     = 1'b0;
        RESET       = 1'b1;

        // Reset held for two cycles
        applyStimulus(3'd0, 1'b0, 1'b1);
        applyStimulus(3'd0, 1'b0, 1'b1);
        checkOutput("reset", 5'h00, 1'b0, 8'd0, 1'b0, 1'b0);

        // Basic sequence 0,1,2,3,4,0,1
        applyStimulus(3'd0, 1'b0, 1'b0); checkOutput("seq0",  5'h01, 1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(3'd1, 1'b0, 1'b0); checkOutput("seq1",  5'h02, 1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(3'd2, 1'b0, 1'b0); checkOutput("seq2",  5'h04, 1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(3'd3, 1'b0, 1'b0); checkOutput("seq3",  5'h08, 1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(3'd4, 1'b0, 1'b0); checkOutput("seq4",  5'h10, 1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(3'd0, 1'b0, 1'b0); checkOutput("wrap0", 5'h01, 1'b1, 8'd1, 1'b1, 1'b0);
        applyStimulus(3'd1, 1'b0, 1'b0); checkOutput("post1", 5'h02, 1'b0, 8'd1, 1'b1, 1'b0);

        // Clear, relock, then 256 full cycles to roll CYCLES over
        applyStimulus(3'd1, 1'b1, 1'b0); checkOutput("clr1",  5'h00, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(3'd0, 1'b0, 1'b0); checkOutput("lock2", 5'h01, 1'b0, 8'd0, 1'b1, 1'b0);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(3'd1, 1'b0, 1'b0);
            applyStimulus(3'd2, 1'b0, 1'b0);
            applyStimulus(3'd3, 1'b0, 1'b0);
            applyStimulus(3'd4, 1'b0, 1'b0);
            applyStimulus(3'd0, 1'b0, 1'b0);
            if (i == 254)
                checkOutput("wrap255", 5'h01, 1'b1, 8'd255, 1'b1, 1'b0);
            else if (i == 255)
                checkOutput("wrap256", 5'h01, 1'b1, 8'd0, 1'b1, 1'b0);
            else if (i < 3)
                checkOutput("wrapEarly", 5'h01, 1'b1, 8'(i + 1), 1'b1, 1'b0);
        end
        applyStimulus(3'd1, 1'b0, 1'b0); checkOutput("noWrapAfter", 5'h02, 1'b0, 8'd0, 1'b1, 1'b0);

        // One more wrap so CYCLES is nonzero, then a 1->3 skip
        applyStimulus(3'd2, 1'b0, 1'b0);
        applyStimulus(3'd3, 1'b0, 1'b0);
        applyStimulus(3'd4, 1'b0, 1'b0);
        applyStimulus(3'd0, 1'b0, 1'b0); checkOutput("wrapC1", 5'h01, 1'b1, 8'd1, 1'b1, 1'b0);
        applyStimulus(3'd1, 1'b0, 1'b0);
        applyStimulus(3'd3, 1'b0, 1'b0); checkOutput("skip13",  5'h00, 1'b0, 8'd1, 1'b0, 1'b1);
        applyStimulus(3'd4, 1'b0, 1'b0); checkOutput("fault4",  5'h00, 1'b0, 8'd1, 1'b0, 1'b1);
        applyStimulus(3'd0, 1'b0, 1'b0); checkOutput("fault0",  5'h00, 1'b0, 8'd1, 1'b0, 1'b1);
        applyStimulus(3'd1, 1'b0, 1'b0); checkOutput("fault1",  5'h00, 1'b0, 8'd1, 1'b0, 1'b1);
        applyStimulus(3'd0, 1'b1, 1'b0); checkOutput("clrFault", 5'h00, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(3'd2, 1'b0, 1'b0); checkOutput("syncWait", 5'h00, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(3'd0, 1'b0, 1'b0); checkOutput("relock",   5'h01, 1'b0, 8'd0, 1'b1, 1'b0);

        // Unlocked values in SYNC, then an out-of-range value while tracking
        applyStimulus(3'd0, 1'b1, 1'b0);
        applyStimulus(3'd2, 1'b0, 1'b0); checkOutput("sync2", 5'h00, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(3'd3, 1'b0, 1'b0); checkOutput("sync3", 5'h00, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(3'd5, 1'b0, 1'b0); checkOutput("sync5", 5'h00, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(3'd0, 1'b0, 1'b0); checkOutput("lock3", 5'h01, 1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(3'd5, 1'b0, 1'b0); checkOutput("track5", 5'h00, 1'b0, 8'd0, 1'b0, 1'b1);

        // Repeated value 2,2 while tracking
        applyStimulus(3'd0, 1'b1, 1'b0);
        applyStimulus(3'd0, 1'b0, 1'b0);
        applyStimulus(3'd1, 1'b0, 1'b0);
        applyStimulus(3'd2, 1'b0, 1'b0); checkOutput("hold2a", 5'h04, 1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(3'd2, 1'b0, 1'b0);
`ifdef TRACKER_HOLD_EN
        checkOutput("hold2b", 5'h04, 1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(3'd3, 1'b0, 1'b0); checkOutput("hold3", 5'h08, 1'b0, 8'd0, 1'b1, 1'b0);
`else
        checkOutput("hold2b", 5'h00, 1'b0, 8'd0, 1'b0, 1'b1);
`endif

        // RESET together with CLR on a 4->0 step: no wrap, everything at reset
        applyStimulus(3'd0, 1'b1, 1'b0);
        applyStimulus(3'd0, 1'b0, 1'b0);
        applyStimulus(3'd1, 1'b0, 1'b0);
        applyStimulus(3'd2, 1'b0, 1'b0);
        applyStimulus(3'd3, 1'b0, 1'b0);
        applyStimulus(3'd4, 1'b0, 1'b0); checkOutput("pre4", 5'h10, 1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(3'd0, 1'b1, 1'b1); checkOutput("rstClr", 5'h00, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(3'd1, 1'b0, 1'b0); checkOutput("afterRst", 5'h00, 1'b0, 8'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
